// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// - owner_t: who holds the memory across clock edges (nobody, or a DMA burst).
// - Default values for the starvation limit and the maximum DMA burst length.
package dmem_arbiter_pkg;

    typedef enum logic {
        OWN_NONE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    localparam int DEF_STARVE_LIMIT = 8;
    localparam int DEF_BURST_MAX    = 16;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one data memory (combinational read, write on
// the clk edge) between the pipeline memory stage (cpu_*) and a DMA/loader
// port (dma_*).
// The CPU has priority. A starvation counter forces one DMA beat in after
// STARVE_LIMIT consecutive CPU grants while DMA is waiting. Once a DMA beat is
// granted, DMA keeps the memory for up to BURST_MAX beats, or until dma_last.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata   memory-stage access request
//   cpu_rdata           load data (straight from the memory)
//   cpu_stall           CPU request not granted this cycle
//   dma_req/we/addr/wdata/last  DMA beat request
//   dma_gnt             DMA beat accepted this cycle
//   dma_rdata/rvalid    registered DMA read data, valid for one cycle
//   mem_a/wd/we, mem_rd memory interface
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int BURST_MAX    = DEF_BURST_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    owner_t        own_reg,        own_next;
    logic [BW-1:0] beat_cnt_reg,   beat_cnt_next;
    logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
    logic [DW-1:0] dma_rdata_reg,  dma_rdata_next;
    logic          dma_rvalid_reg, dma_rvalid_next;

    logic cpu_grant;
    logic dma_grant;
    logic starved;
    logic beat_at_max;

    assign starved     = (starve_cnt_reg == SW'(STARVE_LIMIT));
    assign beat_at_max = (beat_cnt_reg == BW'(BURST_MAX - 1));

    // Grant decision. Everything is gated by rst so that, while reset is
    // held, nothing is granted, no write reaches the memory and any CPU
    // request shows up as a stall.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (rst) begin
            if (own_reg == OWN_DMA && dma_req) begin
                dma_grant = 1'b1;                 // burst continuation
            end else if (cpu_req && !(dma_req && starved)) begin
                cpu_grant = 1'b1;
            end else if (dma_req) begin
                dma_grant = 1'b1;                 // idle memory or starvation
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_grant;
    assign dma_gnt   = dma_grant;

    // The CPU side is the default path of the mux; its write only counts
    // when it actually holds the grant.
    always_comb begin
        mem_a  = cpu_addr;
        mem_wd = cpu_wdata;
        mem_we = cpu_we & cpu_grant;
        if (dma_grant) begin
            mem_a  = dma_addr;
            mem_wd = dma_wdata;
            mem_we = dma_we;
        end
    end

    assign cpu_rdata  = mem_rd;
    assign dma_rdata  = dma_rdata_reg;
    assign dma_rvalid = dma_rvalid_reg;

    always_comb begin
        own_next        = own_reg;
        beat_cnt_next   = beat_cnt_reg;
        starve_cnt_next = starve_cnt_reg;
        dma_rdata_next  = dma_rdata_reg;
        dma_rvalid_next = 1'b0;
        if (dma_grant) begin
            // Ownership ends on the last beat or when the burst cap is hit;
            // the next beat then competes with the CPU again.
            if (dma_last || beat_at_max) begin
                own_next      = OWN_NONE;
                beat_cnt_next = '0;
            end else begin
                own_next      = OWN_DMA;
                beat_cnt_next = beat_cnt_reg + BW'(1);
            end
            starve_cnt_next = '0;
            if (!dma_we) begin
                dma_rdata_next  = mem_rd;
                dma_rvalid_next = 1'b1;
            end
        end else begin
            if (dma_req && cpu_grant && !starved) begin
                starve_cnt_next = starve_cnt_reg + SW'(1);
            end
            if (!dma_req) begin
                starve_cnt_next = '0;
            end
            // Requester went away mid-burst: give the memory back.
            if (own_reg == OWN_DMA && !dma_req) begin
                own_next      = OWN_NONE;
                beat_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_reg        <= OWN_NONE;
            beat_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
            dma_rdata_reg  <= '0;
            dma_rvalid_reg <= 1'b0;
        end else begin
            own_reg        <= own_next;
            beat_cnt_reg   <= beat_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
            dma_rdata_reg  <= dma_rdata_next;
            dma_rvalid_reg <= dma_rvalid_next;
        end
    end

endmodule
